// File: rtl/usb_host_pkg.sv
// Shared types and constants for the host-side USB full-speed transmitter.
package usb_host_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} tx_state_t;

    typedef struct packed {
        logic d_p;
        logic d_n;
    } line_t;

    localparam line_t      LINE_J      = '{d_p: 1'b1, d_n: 1'b0};
    localparam line_t      LINE_K      = '{d_p: 1'b0, d_n: 1'b1};
    localparam line_t      LINE_SE0    = '{d_p: 1'b0, d_n: 1'b0};
    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_host_tx_nrzi.sv
// NRZI line encoder with bit-stuff tracking; updates the line once per bit strobe.
module usb_host_tx_nrzi
    import usb_host_pkg::*;
(
    input  logic clk48,
    input  logic reset,
    input  logic strobe,
    input  logic bit_en,
    input  logic bit_val,
    input  logic stuff_req,
    input  logic se0,
    output logic d_p,
    output logic d_n,
    output logic stuff_pending
);

    logic [2:0] ones;
    logic       lvl_j;
    line_t      line_q;

    // With no request asserted the line is driven to J and the encoder re-arms from J.
    always_ff @(posedge clk48) begin
        if (reset) begin
            ones   <= 3'd0;
            lvl_j  <= 1'b1;
            line_q <= LINE_J;
        end else if (strobe) begin
            if (se0) begin
                line_q <= LINE_SE0;
                ones   <= 3'd0;
            end else if (stuff_req || (bit_en && !bit_val)) begin
                lvl_j  <= !lvl_j;
                line_q <= lvl_j ? LINE_K : LINE_J;
                ones   <= 3'd0;
            end else if (bit_en) begin
                line_q <= lvl_j ? LINE_J : LINE_K;
                ones   <= ones + 3'd1;
            end else begin
                lvl_j  <= 1'b1;
                line_q <= LINE_J;
                ones   <= 3'd0;
            end
        end
    end

    assign d_p           = line_q.d_p;
    assign d_n           = line_q.d_n;
    assign stuff_pending = (ones == 3'(STUFF_LIMIT));

endmodule

// File: rtl/usb_host_tx.sv
// Host-side USB full-speed packet transmitter: SYNC, NRZI/bit-stuffed bytes, EOP.
module usb_host_tx
    import usb_host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk48,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       usb_d_p,
    output logic       usb_d_n,
    output logic       usb_tx_en,
    output logic       o_busy,
    output logic       o_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;
    logic          tick;
    tx_state_t     state;
    logic [7:0]    hold;
    logic          hold_last;
    logic [7:0]    sreg;
    logic [2:0]    bcnt;
    logic          cur_last;
    logic          discard;
    logic          stuff_pending;
    logic          bit_en, bit_val, stuff_req, se0;
    logic          at_boundary, underrun;

    assign tick        = (cnt == CW'(CLKS_PER_BIT - 1));
    assign at_boundary = (state == SYNC || state == DATA) && bcnt == 3'd0 && !stuff_pending;
    assign underrun    = tick && at_boundary && !cur_last && o_ready;

    // Symbol to put on the line at the coming strobe; o_ready low means hold is full.
    always_comb begin
        bit_en    = 1'b0;
        bit_val   = 1'b0;
        stuff_req = 1'b0;
        se0       = 1'b0;
        case (state)
            IDLE: begin
                bit_en  = !o_ready;
                bit_val = SYNC_BYTE[0];
            end
            SYNC, DATA: begin
                if (stuff_pending) begin
                    stuff_req = 1'b1;
                end else if (bcnt != 3'd0) begin
                    bit_en  = 1'b1;
                    bit_val = sreg[0];
                end else if (!cur_last && !o_ready) begin
                    bit_en  = 1'b1;
                    bit_val = hold[0];
                end else begin
                    se0 = 1'b1;
                end
            end
            EOP_SE0: se0 = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (reset) begin
            cnt       <= '0;
            state     <= IDLE;
            hold      <= 8'd0;
            hold_last <= 1'b0;
            sreg      <= 8'd0;
            bcnt      <= 3'd0;
            cur_last  <= 1'b0;
            discard   <= 1'b0;
            o_ready   <= 1'b1;
            usb_tx_en <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            cnt   <= tick ? '0 : cnt + CW'(1);
            o_err <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        usb_tx_en <= !o_ready;
                        if (!o_ready) begin
                            state    <= SYNC;
                            o_busy   <= 1'b1;
                            sreg     <= SYNC_BYTE >> 1;
                            bcnt     <= 3'd7;
                            cur_last <= 1'b0;
                        end
                    end
                    SYNC, DATA: begin
                        if (!stuff_pending) begin
                            if (bcnt != 3'd0) begin
                                sreg <= sreg >> 1;
                                bcnt <= bcnt - 3'd1;
                            end else if (cur_last) begin
                                state <= EOP_SE0;
                            end else if (!o_ready) begin
                                sreg     <= hold >> 1;
                                bcnt     <= 3'd7;
                                cur_last <= hold_last;
                                o_ready  <= 1'b1;
                                state    <= DATA;
                            end else begin
                                o_err   <= 1'b1;
                                discard <= 1'b1;
                                state   <= EOP_SE0;
                            end
                        end
                    end
                    EOP_SE0: state <= EOP_J;
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
            // Placed after the FSM so a last byte arriving on the underrun cycle ends discard.
            if (i_valid && o_ready) begin
                if (discard || underrun) begin
                    if (i_last) discard <= 1'b0;
                end else begin
                    hold      <= i_data;
                    hold_last <= i_last;
                    o_ready   <= 1'b0;
                end
            end
        end
    end

    usb_host_tx_nrzi u_nrzi (
        .clk48        (clk48),
        .reset        (reset),
        .strobe       (tick),
        .bit_en       (bit_en),
        .bit_val      (bit_val),
        .stuff_req    (stuff_req),
        .se0          (se0),
        .d_p          (usb_d_p),
        .d_n          (usb_d_n),
        .stuff_pending(stuff_pending)
    );

endmodule

// File: tb/tb_usb_host_tx.sv
// Scoreboard bench for usb_host_tx: expected packets are queued by stimulus, checked by a line monitor.
module tb_usb_host_tx;

    logic       clk48 = 1'b0;
    logic       reset;
    logic [7:0] i_data;
    logic       i_last;
    logic [1:0] vld;
    wire  [1:0] rdy, dp, dn, en, busy, err;

    always #5 clk48 = ~clk48;

    usb_host_tx #(.CLKS_PER_BIT(4)) u_dut (
        .clk48(clk48), .reset(reset), .i_data(i_data), .i_last(i_last), .i_valid(vld[0]),
        .o_ready(rdy[0]), .usb_d_p(dp[0]), .usb_d_n(dn[0]), .usb_tx_en(en[0]),
        .o_busy(busy[0]), .o_err(err[0])
    );

    usb_host_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk48(clk48), .reset(reset), .i_data(i_data), .i_last(i_last), .i_valid(vld[1]),
        .o_ready(rdy[1]), .usb_d_p(dp[1]), .usb_d_n(dn[1]), .usb_tx_en(en[1]),
        .o_busy(busy[1]), .o_err(err[1])
    );

    localparam string SYNC_S = "KJKJKJKK";
    localparam string ACK_S  = {SYNC_S, "JJKJJKKK", "SSJ"};

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    string exp_s0[$], exp_s1[$];
    int    exp_c0[$], exp_c1[$];
    int    exp_e0[$], exp_e1[$];
    int    hs_cnt[2], hs_cyc[2], kc[2], errc[2], lat[2], npkt[2], err_total[2];
    bit    act[2];
    string cap[2];
    int    idle_bad = 0;

    function automatic int cpb(input int u);
        return (u == 0) ? 4 : 2;
    endfunction

    function automatic string sym(input logic p, input logic n);
        if (p === 1'b1 && n === 1'b0) return "J";
        if (p === 1'b0 && n === 1'b1) return "K";
        if (p === 1'b0 && n === 1'b0) return "S";
        return "X";
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_str(input string name, input string got, input string want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    task automatic push_exp(input int u, input string s, input int c, input int e);
        if (u == 0) begin exp_s0.push_back(s); exp_c0.push_back(c); exp_e0.push_back(e); end
        else        begin exp_s1.push_back(s); exp_c1.push_back(c); exp_e1.push_back(e); end
    endtask

    task automatic finish_pkt(input int u);
        string s;
        int    c, e;
        npkt[u]++;
        if ((u == 0 && exp_s0.size() == 0) || (u == 1 && exp_s1.size() == 0)) begin
            check($sformatf("unexpected_pkt_u%0d", u), 1, 0);
        end else begin
            if (u == 0) begin s = exp_s0.pop_front(); c = exp_c0.pop_front(); e = exp_e0.pop_front(); end
            else        begin s = exp_s1.pop_front(); c = exp_c1.pop_front(); e = exp_e1.pop_front(); end
            check_str($sformatf("line_seq_u%0d_p%0d", u, npkt[u]), cap[u], s);
            check($sformatf("tx_en_cycles_u%0d_p%0d", u, npkt[u]), kc[u], c);
            check($sformatf("err_pulses_u%0d_p%0d", u, npkt[u]), errc[u], e);
            check($sformatf("start_latency_ok_u%0d_p%0d", u, npkt[u]),
                  int'(lat[u] >= 1 && lat[u] <= cpb(u)), 1);
        end
    endtask

    always @(posedge clk48) begin
        cyc++;
        for (int u = 0; u < 2; u++)
            if (vld[u] === 1'b1 && rdy[u] === 1'b1) begin
                hs_cnt[u]++;
                hs_cyc[u] = cyc;
            end
    end

    // Monitor: captures one symbol per bit time while tx_en is high, checks the packet when it drops.
    always @(negedge clk48) begin
        for (int u = 0; u < 2; u++) begin
            if (reset !== 1'b0) begin
                act[u] = 1'b0;
            end else if (en[u] === 1'b1) begin
                if (!act[u]) begin
                    act[u] = 1'b1; kc[u] = 0; cap[u] = ""; errc[u] = 0;
                    lat[u] = cyc - hs_cyc[u];
                end
                if (kc[u] % cpb(u) == 0) cap[u] = {cap[u], sym(dp[u], dn[u])};
                kc[u]++;
                if (err[u] === 1'b1) errc[u]++;
            end else begin
                if (act[u]) begin
                    act[u] = 1'b0;
                    finish_pkt(u);
                end
                if (!(dp[u] === 1'b1 && dn[u] === 1'b0)) idle_bad++;
            end
            if (reset === 1'b0 && err[u] === 1'b1) err_total[u]++;
        end
    end

    task automatic send_byte(input int u, input logic [7:0] d, input logic l);
        int t = 0;
        @(posedge clk48); #1;
        while (rdy[u] !== 1'b1 && t < 3000) begin @(posedge clk48); #1; t++; end
        check($sformatf("send_ready_u%0d_%02h", u, d), int'(rdy[u] === 1'b1), 1);
        i_data = d; i_last = l; vld[u] = 1'b1;
        @(posedge clk48); #1;
        vld[u] = 1'b0;
    endtask

    task automatic wait_pkts(input int u, input int n);
        int t = 0;
        while (npkt[u] < n && t < 3000) begin @(posedge clk48); t++; end
        check($sformatf("pkt_count_u%0d", u), npkt[u], n);
    endtask

    task automatic check_reset_state(input string tag);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("%s_d_p_u%0d", tag, u), int'(dp[u]), 1);
            check($sformatf("%s_d_n_u%0d", tag, u), int'(dn[u]), 0);
            check($sformatf("%s_tx_en_u%0d", tag, u), int'(en[u]), 0);
            check($sformatf("%s_ready_u%0d", tag, u), int'(rdy[u]), 1);
            check($sformatf("%s_busy_u%0d", tag, u), int'(busy[u]), 0);
            check($sformatf("%s_err_u%0d", tag, u), int'(err[u]), 0);
        end
    endtask

    initial begin
        int h0, t;
        for (int u = 0; u < 2; u++) begin
            hs_cnt[u] = 0; hs_cyc[u] = 0; kc[u] = 0; errc[u] = 0;
            lat[u] = 0; npkt[u] = 0; err_total[u] = 0; act[u] = 1'b0; cap[u] = "";
        end
        reset = 1'b1; vld = 2'b00; i_data = 8'h00; i_last = 1'b0;
        repeat (3) @(posedge clk48);
        #1 check_reset_state("reset");
        reset = 1'b0;

        // ACK
        push_exp(0, ACK_S, 76, 0);
        send_byte(0, 8'hD2, 1'b1);
        wait_pkts(0, 1);

        // 0xFF: stuff bit after the sixth consecutive one
        push_exp(0, {SYNC_S, "KKKKKJJJJ", "SSJ"}, 80, 0);
        send_byte(0, 8'hFF, 1'b1);
        wait_pkts(0, 2);

        // three back-to-back bytes
        h0 = hs_cnt[0];
        push_exp(0, {SYNC_S, "KJKKJJJK", "JKJKJKJK", "JKJKKJKJ", "SSJ"}, 140, 0);
        send_byte(0, 8'h69, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h10, 1'b1);
        wait_pkts(0, 3);
        check("three_byte_handshakes", hs_cnt[0] - h0, 3);

        // underrun: second byte withheld, then a late last byte is dropped
        push_exp(0, {SYNC_S, "JJKJJKKK", "SSJ"}, 76, 1);
        send_byte(0, 8'hD2, 1'b0);
        wait_pkts(0, 4);
        send_byte(0, 8'h55, 1'b1);
        repeat (200) @(posedge clk48);
        #1;
        check("drop_no_new_pkt", npkt[0], 4);
        check("drop_busy", int'(busy[0]), 0);
        check("drop_ready", int'(rdy[0]), 1);

        // reset in the middle of DATA, then a clean ACK
        send_byte(0, 8'hD2, 1'b1);
        t = 0;
        while (en[0] !== 1'b1 && t < 100) begin @(posedge clk48); t++; end
        check("midreset_started", int'(en[0] === 1'b1), 1);
        repeat (48) @(posedge clk48);
        #1 reset = 1'b1;
        @(posedge clk48);
        #1 check_reset_state("midreset");
        reset = 1'b0;
        push_exp(0, ACK_S, 76, 0);
        send_byte(0, 8'hD2, 1'b1);
        wait_pkts(0, 5);

        // ACK at two clocks per bit
        push_exp(1, ACK_S, 38, 0);
        send_byte(1, 8'hD2, 1'b1);
        wait_pkts(1, 1);

        repeat (20) @(posedge clk48);
        check("idle_line_not_j", idle_bad, 0);
        check("err_total_u0", err_total[0], 1);
        check("err_total_u1", err_total[1], 0);
        check("exp_left_u0", exp_s0.size(), 0);
        check("exp_left_u1", exp_s1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
